write_stage: RTL



---
 rtl/write_stage.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/write_stage.sv
// write_stage: final pipeline stage.
// Commits execute results to the architectural register file and publishes
// same-cycle forwarding values. Stores go out through a wait-stated write
// port. A write to the PC register produces a one-cycle redirect to fetch.
// Register 0 reads as zero, PC is index NR-2, and Flags is index NR-1.
// Optional feature: define WRITE_STAGE_DOUBLE_STORE_EN so that a store with
// an upper value writes two consecutive words (address, address+4).
module write_stage #(
    parameter int NR = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_is_valid,
    output logic             in_hold,
    input  logic [31:0]      in_pc,
    input  logic [31:0]      in_adjustment_value,
    input  logic [31:0]      in_target_value,
    input  logic [31:0]      in_upper_value,
    input  logic [4:0]       in_target_register,
    input  logic [3:0]       in_flags,
    input  logic             in_has_flushed,
    input  logic             in_is_writing_memory,
    input  logic             in_has_upper_value,
    output logic [32*NR-1:0] registers,
    output logic [31:0]      fb_value,
    output logic [31:0]      fb_upper_value,
    output logic [4:0]       fb_index,
    output logic             fb_is_valid,
    output logic             fb_has_upper_value,
    output logic [31:0]      next_pc,
    output logic             has_flushed,
    output logic [31:0]      mem_address,
    output logic [31:0]      mem_data,
    output logic             mem_write,
    input  logic             mem_waitrequest
);

    localparam int PC_IDX    = NR - 2;
    localparam int FLAGS_IDX = NR - 1;

    localparam logic [1:0] S_IDLE        = 2'd0;
    localparam logic [1:0] S_STORE       = 2'd1;
`ifdef WRITE_STAGE_DOUBLE_STORE_EN
    localparam logic [1:0] S_STORE_UPPER = 2'd2;
`endif

    logic [1:0]  state;
    logic [1:0]  state_next;
    logic [31:0] regs [NR];
    logic [31:0] store_addr_q;
    logic [31:0] store_data_q;
`ifdef WRITE_STAGE_DOUBLE_STORE_EN
    logic [31:0] store_upper_q;
    logic        store_double_q;
`endif

    logic accept;
    logic commit;
    logic store_accept;
    int   tgt_idx;

    assign accept       = in_is_valid && (state == S_IDLE);
    assign commit       = accept && !in_has_flushed && !in_is_writing_memory;
    assign store_accept = accept && !in_has_flushed && in_is_writing_memory;
    assign tgt_idx      = int'({27'd0, in_target_register});

    assign in_hold   = (state != S_IDLE);
    assign mem_write = (state != S_IDLE);

    // Forwarding view of the instruction committing this cycle.
    assign fb_is_valid        = commit;
    assign fb_index           = in_target_register;
    assign fb_value           = in_target_value;
    assign fb_upper_value     = in_upper_value;
    assign fb_has_upper_value = in_has_upper_value;

    // Store port drives latched operands; the upper word goes to address+4.
`ifdef WRITE_STAGE_DOUBLE_STORE_EN
    assign mem_address = (state == S_STORE_UPPER) ? store_addr_q + 32'd4 : store_addr_q;
    assign mem_data    = (state == S_STORE_UPPER) ? store_upper_q : store_data_q;
`else
    assign mem_address = store_addr_q;
    assign mem_data    = store_data_q;
`endif

    for (genvar g = 0; g < NR; g++) begin : g_flat
        assign registers[32*g +: 32] = regs[g];
    end

    // Next-state logic for the store sequencer.
    always_comb begin
        // NOTE: default assignment first so every path assigns state_next and no latch is inferred.
        state_next = state;
        case (state)
            S_IDLE: begin
                if (store_accept) state_next = S_STORE;
            end
            S_STORE: begin
`ifdef WRITE_STAGE_DOUBLE_STORE_EN
                if (!mem_waitrequest) state_next = store_double_q ? S_STORE_UPPER : S_IDLE;
`else
                if (!mem_waitrequest) state_next = S_IDLE;
`endif
            end
`ifdef WRITE_STAGE_DOUBLE_STORE_EN
            S_STORE_UPPER: begin
                if (!mem_waitrequest) state_next = S_IDLE;
            end
`endif
            default: state_next = S_IDLE;
        endcase
    end

    // State register and store operand capture at accept.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            store_addr_q <= '0;
            store_data_q <= '0;
`ifdef WRITE_STAGE_DOUBLE_STORE_EN
            store_upper_q  <= '0;
            store_double_q <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state <= state_next;
            if (store_accept) begin
                store_addr_q <= in_adjustment_value;
                store_data_q <= in_target_value;
`ifdef WRITE_STAGE_DOUBLE_STORE_EN
                store_upper_q  <= in_upper_value;
                store_double_q <= in_has_upper_value;
`endif
            end
        end
    end

    // Architectural register file: implicit PC/Flags first, explicit targets override.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: this small array is architectural state and must start at zero, so it is reset like any flop.
            for (int i = 0; i < NR; i++) regs[i] <= '0;
        end else begin
            if (commit || store_accept) regs[PC_IDX] <= in_pc + 32'd4;
            if (commit) begin
                regs[FLAGS_IDX] <= {28'd0, in_flags};
                for (int i = 1; i < NR; i++) begin
                    if (in_has_upper_value && (tgt_idx + 1 == i)) regs[i] <= in_upper_value;
                    if (tgt_idx == i) regs[i] <= in_target_value;
                end
            end
        end
    end

    // Registered redirect pulse when a committed result targets the PC.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            has_flushed <= 1'b0;
            next_pc     <= '0;
        end else begin
            has_flushed <= commit && (tgt_idx == PC_IDX);
            if (commit && (tgt_idx == PC_IDX)) next_pc <= in_target_value;
        end
    end

endmodule
